// File: rtl/clkswitch_pkg.sv
// -----------------------------------------------------------------------------
// clkswitch_pkg
// Shared definitions for the CPU clock-switch controller:
//   - state_t        : 2-bit controller state encoding
//   - *_DEF          : default parameter values for clkswitch_ctrl
//   - cnt_width()    : counter width helper, never narrower than 1 bit
// -----------------------------------------------------------------------------
package clkswitch_pkg;

  localparam int STATE_W            = 2;
  localparam int SYNC_STAGES_DEF    = 2;
  localparam int DWELL_CYCLES_DEF   = 8;
  localparam int TIMEOUT_CYCLES_DEF = 255;

  typedef enum logic [STATE_W-1:0] {
    LS_ACTIVE = 2'd0,
    TO_HS     = 2'd1,
    HS_ACTIVE = 2'd2,
    TO_LS     = 2'd3
  } state_t;

  // Bits needed to hold values 0..n-1.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clkswitch_sync.sv
// -----------------------------------------------------------------------------
// clkswitch_sync
// Multi-flop synchroniser for an asynchronous level into the hsclk_in domain.
// Ports:
//   hsclk_in : sampling clock
//   rst_b    : asynchronous active-low reset, clears every flop to 0
//   d        : asynchronous input level
//   q        : synchronised level, STAGES cycles of latency
// -----------------------------------------------------------------------------
module clkswitch_sync #(
  parameter int STAGES = 2
) (
  input  logic hsclk_in,
  input  logic rst_b,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge hsclk_in or negedge rst_b) begin
    if (!rst_b) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/clkswitch_ctrl.sv
// -----------------------------------------------------------------------------
// clkswitch_ctrl
// Handshaking controller that moves the CPU between the low-speed and the
// high-speed clock through an external glitch-free clock switcher.
// Ports:
//   hsclk_in       : controller clock, all state updates on its rising edge
//   rst_b          : asynchronous active-low reset (returns to LS immediately)
//   req_hs         : level request for the high-speed clock
//   force_ls       : level forcing low speed, overrides req_hs and dwell
//   hsclk_selected : async ack from switcher, LS clock stopped
//   lsclk_selected : async ack from switcher, HS clock stopped
//   hsclk_sel      : registered select to the switcher (1 = HS)
//   speed_hs       : registered, high only while running on HS
//   busy           : registered, high while a switch is in progress
//   timeout_err    : registered sticky flag, a switch waited too long
// -----------------------------------------------------------------------------
module clkswitch_ctrl
  import clkswitch_pkg::*;
#(
  parameter int SYNC_STAGES    = SYNC_STAGES_DEF,
  parameter int DWELL_CYCLES   = DWELL_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic hsclk_in,
  input  logic rst_b,
  input  logic req_hs,
  input  logic force_ls,
  input  logic hsclk_selected,
  input  logic lsclk_selected,
  output logic hsclk_sel,
  output logic speed_hs,
  output logic busy,
  output logic timeout_err
);

  localparam int WAIT_W  = cnt_width(TIMEOUT_CYCLES + 1);
  localparam int DWELL_W = cnt_width(DWELL_CYCLES);

  localparam logic [WAIT_W-1:0]  WAIT_MAX   = WAIT_W'(TIMEOUT_CYCLES);
  localparam logic [WAIT_W-1:0]  BLANK_LEN  = WAIT_W'(SYNC_STAGES);
  localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DWELL_CYCLES - 1);

  logic ack_hs_s;
  logic ack_ls_s;

  state_t             state, state_nxt;
  logic [WAIT_W-1:0]  wait_cnt, wait_nxt, wait_inc;
  logic [DWELL_W-1:0] dwell_cnt, dwell_nxt;
  logic               tmo_nxt;
  logic               blank_done;

  clkswitch_sync #(.STAGES(SYNC_STAGES)) u_sync_hs (
    .hsclk_in (hsclk_in),
    .rst_b    (rst_b),
    .d        (hsclk_selected),
    .q        (ack_hs_s)
  );

  clkswitch_sync #(.STAGES(SYNC_STAGES)) u_sync_ls (
    .hsclk_in (hsclk_in),
    .rst_b    (rst_b),
    .d        (lsclk_selected),
    .q        (ack_ls_s)
  );

  // The synchroniser may still hold the acknowledge from the previous switch;
  // it only becomes trustworthy once it has been refilled after entry.
  assign blank_done = (wait_cnt > BLANK_LEN);
  assign wait_inc   = (wait_cnt == WAIT_MAX) ? WAIT_MAX : wait_cnt + WAIT_W'(1);

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    dwell_nxt = dwell_cnt;
    tmo_nxt   = timeout_err;
    case (state)
      LS_ACTIVE: begin
        if (req_hs && !force_ls) begin
          state_nxt = TO_HS;
          wait_nxt  = '0;
        end
      end
      TO_HS: begin
        if (blank_done && ack_hs_s) begin
          state_nxt = HS_ACTIVE;
          dwell_nxt = DWELL_LOAD;
        end else begin
          wait_nxt = wait_inc;
          tmo_nxt  = timeout_err | (wait_inc == WAIT_MAX);
        end
      end
      HS_ACTIVE: begin
        if (force_ls || (!req_hs && (dwell_cnt == '0))) begin
          state_nxt = TO_LS;
          wait_nxt  = '0;
        end else if (dwell_cnt != '0) begin
          dwell_nxt = dwell_cnt - DWELL_W'(1);
        end
      end
      TO_LS: begin
        if (blank_done && ack_ls_s) begin
          state_nxt = LS_ACTIVE;
        end else begin
          wait_nxt = wait_inc;
          tmo_nxt  = timeout_err | (wait_inc == WAIT_MAX);
        end
      end
      default: begin
        state_nxt = LS_ACTIVE;
      end
    endcase
  end

  // Outputs are decoded from the next state so each one is a plain flop.
  always_ff @(posedge hsclk_in or negedge rst_b) begin
    if (!rst_b) begin
      state       <= LS_ACTIVE;
      wait_cnt    <= '0;
      dwell_cnt   <= '0;
      hsclk_sel   <= 1'b0;
      speed_hs    <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_nxt;
      dwell_cnt   <= dwell_nxt;
      hsclk_sel   <= (state_nxt == TO_HS) || (state_nxt == HS_ACTIVE);
      speed_hs    <= (state_nxt == HS_ACTIVE);
      busy        <= (state_nxt == TO_HS) || (state_nxt == TO_LS);
      timeout_err <= tmo_nxt;
    end
  end

endmodule

// File: tb/tb_clkswitch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clkswitch_ctrl
// Directed scenarios plus a randomized run of clkswitch_ctrl against a
// behavioural model built on "phase + time spent in phase" bookkeeping and a
// history of raw acknowledge samples. A simple switcher model answers
// hsclk_sel with break-before-make acknowledges after a programmable delay.
// -----------------------------------------------------------------------------
module tb_clkswitch_ctrl;

  localparam int SYNC  = 2;
  localparam int DWELL = 8;
  localparam int TMO   = 255;

  logic hsclk_in = 1'b0;
  logic rst_b;
  logic req_hs;
  logic force_ls;
  logic hsclk_selected;
  logic lsclk_selected;
  logic hsclk_sel;
  logic speed_hs;
  logic busy;
  logic timeout_err;

  always #5 hsclk_in = ~hsclk_in;

  clkswitch_ctrl #(
    .SYNC_STAGES    (SYNC),
    .DWELL_CYCLES   (DWELL),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .hsclk_in       (hsclk_in),
    .rst_b          (rst_b),
    .req_hs         (req_hs),
    .force_ls       (force_ls),
    .hsclk_selected (hsclk_selected),
    .lsclk_selected (lsclk_selected),
    .hsclk_sel      (hsclk_sel),
    .speed_hs       (speed_hs),
    .busy           (busy),
    .timeout_err    (timeout_err)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: phase 0 = on LS, 1 = going up, 2 = on HS, 3 = going down.
  int m_phase;
  int m_t;
  bit m_to;
  bit hq[$];
  bit lq[$];

  // Switcher model
  bit   auto_ack;
  bit   rnd_dly;
  int   ack_dly;
  int   sw_cnt;
  logic last_sel;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_t     = 0;
    m_to    = 1'b0;
    hq.delete();
    lq.delete();
  endtask

  // One rising edge of the reference model, using the input levels present
  // just before the edge. The acknowledge seen through SYNC flops at this
  // edge is the raw level sampled SYNC edges earlier.
  task automatic model_edge();
    bit ah;
    bit al;
    ah = (hq.size() >= SYNC) ? hq[0] : 1'b0;
    al = (lq.size() >= SYNC) ? lq[0] : 1'b0;
    hq.push_back(hsclk_selected === 1'b1);
    lq.push_back(lsclk_selected === 1'b1);
    if (hq.size() > SYNC) void'(hq.pop_front());
    if (lq.size() > SYNC) void'(lq.pop_front());
    case (m_phase)
      0: begin
        if (req_hs && !force_ls) begin
          m_phase = 1;
          m_t     = 0;
        end
      end
      1, 3: begin
        if (m_t > SYNC && ((m_phase == 1) ? ah : al)) begin
          m_phase = (m_phase + 1) % 4;
          m_t     = 0;
        end else begin
          if (m_t < TMO) m_t++;
          if (m_t == TMO) m_to = 1'b1;
        end
      end
      default: begin
        if (force_ls || (!req_hs && m_t >= DWELL - 1)) begin
          m_phase = 3;
          m_t     = 0;
        end else if (m_t < DWELL) begin
          m_t++;
        end
      end
    endcase
  endtask

  task automatic step();
    @(posedge hsclk_in);
    if (rst_b) model_edge();
    else       model_reset();
    #1;
    chk("hsclk_sel",   hsclk_sel,   logic'(m_phase == 1 || m_phase == 2));
    chk("speed_hs",    speed_hs,    logic'(m_phase == 2));
    chk("busy",        busy,        logic'(m_phase == 1 || m_phase == 3));
    chk("timeout_err", timeout_err, logic'(m_to));
    if (hsclk_sel !== last_sel) begin
      last_sel = hsclk_sel;
      sw_cnt   = 0;
      if (rnd_dly) ack_dly = $urandom_range(1, 6);
      if (auto_ack) begin
        hsclk_selected = 1'b0;
        lsclk_selected = 1'b0;
      end
    end else if (sw_cnt < 1000) begin
      sw_cnt++;
    end
    if (auto_ack && sw_cnt >= ack_dly) begin
      hsclk_selected = last_sel;
      lsclk_selected = ~last_sel;
    end
  endtask

  task automatic run_until(input string tag, input bit use_busy, input logic val,
                           input int budget);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      step();
      hit = use_busy ? (busy === val) : (speed_hs === val);
    end
    chk(tag, hit, 1'b1);
  endtask

  initial begin
    rst_b          = 1'b0;
    req_hs         = 1'b0;
    force_ls       = 1'b0;
    hsclk_selected = 1'b0;
    lsclk_selected = 1'b1;
    auto_ack       = 1'b1;
    rnd_dly        = 1'b0;
    ack_dly        = 5;
    sw_cnt         = 100;
    last_sel       = 1'b0;
    model_reset();

    // Reset state
    repeat (2) @(posedge hsclk_in);
    #1;
    chk("rst_hsclk_sel",   hsclk_sel,   1'b0);
    chk("rst_speed_hs",    speed_hs,    1'b0);
    chk("rst_busy",        busy,        1'b0);
    chk("rst_timeout_err", timeout_err, 1'b0);
    rst_b = 1'b1;
    repeat (3) step();

    // LS -> HS with the acknowledge arriving 5 cycles after the select
    req_hs = 1'b1;
    step();
    chk("up_sel_next_cycle", hsclk_sel, 1'b1);
    chk("up_busy",           busy,      1'b1);
    run_until("up_reach_hs", 1'b0, 1'b1, 30);

    // Drop the request at dwell cycle 3; stays on HS until dwell expires
    repeat (3) step();
    req_hs = 1'b0;
    repeat (2) step();
    chk("dwell_sel_held", hsclk_sel, 1'b1);
    run_until("dwell_leave_hs", 1'b0, 1'b0, 20);
    run_until("dwell_reach_ls", 1'b1, 1'b0, 30);

    // Force LS at dwell cycle 1
    req_hs = 1'b1;
    run_until("force_reach_hs", 1'b0, 1'b1, 30);
    step();
    force_ls = 1'b1;
    step();
    chk("force_sel_low",   hsclk_sel, 1'b0);
    chk("force_speed_low", speed_hs,  1'b0);
    chk("force_busy",      busy,      1'b1);
    run_until("force_reach_ls", 1'b1, 1'b0, 30);
    step();
    chk("force_blocks_req", hsclk_sel, 1'b0);
    force_ls = 1'b0;
    req_hs   = 1'b0;
    repeat (2) step();

    // Stale hsclk_selected at TO_HS entry must be blanked
    auto_ack       = 1'b0;
    hsclk_selected = 1'b1;
    repeat (3) step();
    req_hs = 1'b1;
    step();
    for (int i = 0; i < SYNC + 1; i++) begin
      step();
      chk("stale_still_busy", busy, 1'b1);
    end
    auto_ack = 1'b1;
    run_until("stale_reach_hs", 1'b0, 1'b1, 30);
    req_hs = 1'b0;
    run_until("stale_leave_hs", 1'b0, 1'b0, 20);
    run_until("stale_reach_ls", 1'b1, 1'b0, 30);

    // Acknowledge never arrives -> sticky timeout
    auto_ack       = 1'b0;
    hsclk_selected = 1'b0;
    lsclk_selected = 1'b1;
    req_hs         = 1'b1;
    repeat (TMO + 5) step();
    chk("tmo_set",       timeout_err, 1'b1);
    chk("tmo_busy",      busy,        1'b1);
    hsclk_selected = 1'b1;
    lsclk_selected = 1'b0;
    run_until("tmo_late_ack_hs", 1'b0, 1'b1, 10);
    chk("tmo_sticky", timeout_err, 1'b1);
    auto_ack = 1'b1;
    req_hs   = 1'b0;
    run_until("tmo_leave_hs", 1'b0, 1'b0, 20);
    run_until("tmo_reach_ls", 1'b1, 1'b0, 30);
    chk("tmo_sticky_ls", timeout_err, 1'b1);
    #2;
    rst_b = 1'b0;
    #1;
    chk("tmo_cleared_by_rst", timeout_err, 1'b0);
    model_reset();
    rst_b = 1'b1;
    repeat (2) step();

    // Reset pulse mid-TO_HS, no clock edge; request held through reset
    req_hs = 1'b1;
    repeat (2) step();
    chk("midrst_pre_busy", busy, 1'b1);
    #2;
    rst_b = 1'b0;
    #1;
    chk("midrst_sel_low",  hsclk_sel, 1'b0);
    chk("midrst_busy_low", busy,      1'b0);
    model_reset();
    #1;
    rst_b = 1'b1;
    step();
    chk("post_rst_req_seen", hsclk_sel, 1'b1);
    run_until("post_rst_reach_hs", 1'b0, 1'b1, 30);

    // Randomized traffic
    rnd_dly = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) req_hs = ~req_hs;
      force_ls = ($urandom_range(0, 24) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clkswitch_ctrl.md
CLKSWITCH_CTRL -- requirements
Module: clkswitch_ctrl

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: flops in each acknowledge synchroniser; minimum 2.
REQ-002 SHALL have parameter DWELL_CYCLES, default 8: minimum hsclk_in cycles held in HS before a voluntary return to LS.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255: switch-wait limit before timeout_err is flagged.
REQ-004 SHALL have port hsclk_in  input  1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_b  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port req_hs  input  1: level request for the high-speed CPU clock, synchronous to hsclk_in.
REQ-007 SHALL have port force_ls  input  1: synchronous level that forces low speed (slow-bus access); overrides req_hs and the dwell count.
REQ-008 SHALL have port hsclk_selected  input  1: asynchronous acknowledge from the clock switcher that the LS clock is stopped.
REQ-009 SHALL have port lsclk_selected  input  1: asynchronous acknowledge from the clock switcher that the HS clock is stopped.
REQ-010 SHALL have port hsclk_sel  output  1: registered select to the clock switcher (1 = HS).
REQ-011 SHALL have port speed_hs  output  1: registered; high only in state HS_ACTIVE.
REQ-012 SHALL have port busy  output  1: registered; high in states TO_HS and TO_LS.
REQ-013 SHALL have port timeout_err  output  1: registered, sticky timeout flag.

Function
REQ-014 SHALL implement states LS_ACTIVE, TO_HS, HS_ACTIVE and TO_LS.
REQ-015 SHALL pass hsclk_selected and lsclk_selected through SYNC_STAGES flops each before use (ack_hs_s, ack_ls_s).
REQ-016 SHALL, in LS_ACTIVE, go to TO_HS on req_hs=1 and force_ls=0, with hsclk_sel=1 from the next cycle.
REQ-017 SHALL, on every TO_HS/TO_LS entry, clear a wait counter that increments each cycle in the state and saturates at TIMEOUT_CYCLES.
REQ-018 SHALL ignore the acknowledge while wait counter <= SYNC_STAGES (blanks stale synchronised values).
REQ-019 SHALL, in TO_HS, go to HS_ACTIVE on ack_hs_s=1 once blanking has expired, loading the dwell counter with DWELL_CYCLES-1.
REQ-020 SHALL, in HS_ACTIVE, decrement the dwell counter to 0 and hold it there.
REQ-021 SHALL leave HS_ACTIVE for TO_LS, with hsclk_sel=0 from the next cycle, when force_ls=1, or when req_hs=0 and the dwell counter is 0.
REQ-022 SHALL, in TO_LS, go to LS_ACTIVE on ack_ls_s=1 once blanking has expired.
REQ-023 SHALL never abort a switch in progress; req_hs/force_ls changes during TO_HS/TO_LS are acted on only after the target state is reached.
REQ-024 SHALL treat req_hs=1 and force_ls=1 together as force_ls: no transition out of LS_ACTIVE, and exit from HS_ACTIVE.
REQ-025 SHALL set timeout_err when the wait counter reaches TIMEOUT_CYCLES, while continuing to wait in the same state.
REQ-026 SHALL keep timeout_err set until reset.
REQ-027 SHALL change hsclk_sel only on state entry to TO_HS or TO_LS; it is glitch-free (direct flop output).
REQ-028 SHALL have wait counter width ceil(log2(TIMEOUT_CYCLES+1)) and dwell counter width ceil(log2(DWELL_CYCLES)), minimum 1.

Reset
REQ-029 SHALL, while rst_b=0, asynchronously force: state LS_ACTIVE; hsclk_sel=0 (matches switcher LS-enabled reset); speed_hs=0; busy=0; timeout_err=0; counters 0; synchroniser flops 0.
REQ-030 SHALL, on reset asserted mid-switch, return hsclk_sel to 0 immediately, with no further handshake required.
REQ-031 SHALL evaluate req_hs only from the first hsclk_in rising edge after rst_b deasserts.

Structure
REQ-032 SHALL place state encodings (2-bit) and default parameter values in shared package clkswitch_pkg.
REQ-033 SHALL instantiate the synchroniser twice as sub-module clkswitch_sync (parameterised depth, async active-low reset to 0).
REQ-034 SHALL contain no combinational path from any input to any output.

Verification
REQ-035 SHALL cover: req_hs 0->1 with hsclk_selected rising 5 cycles later -> hsclk_sel=1 one cycle after request; busy for blanking+sync; speed_hs=1 after ack_hs_s.
REQ-036 SHALL cover: in HS_ACTIVE, req_hs dropped at dwell cycle 3 (DWELL=8) -> hsclk_sel remains 1 until dwell reaches 0, then 0 next cycle.
REQ-037 SHALL cover: in HS_ACTIVE, force_ls=1 at dwell cycle 1 -> hsclk_sel=0 next cycle; speed_hs=0; LS_ACTIVE after lsclk_selected ack.
REQ-038 SHALL cover: hsclk_selected held 1 (stale) at TO_HS entry -> no transition before SYNC_STAGES+1 cycles.
REQ-039 SHALL cover: acknowledge never arrives -> timeout_err=1 at cycle 255, still 1 after the late ack completes the switch, cleared only by rst_b.
REQ-040 SHALL cover: rst_b pulsed low mid-TO_HS -> hsclk_sel=0, busy=0 with no clock edge; LS_ACTIVE after release.
